// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file (regfile_mp).
// Holds the clear-FSM state encoding, default geometry and the index range check.
package regfile_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // DEPTH need not be a power of two, so a full-width select can point past the array.
  function automatic logic idx_in_range(input logic [31:0] idx, input int depth);
    return (idx < 32'(depth));
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port of regfile_mp: range-checked mux with optional write-through.
// Bypass is gated by byp_en_i, which the top ties low when forwarding is not built in.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] mem_i,
  input  logic [DEPTH-1:0]            vld_i,
  input  logic [ADDR_W-1:0]           sel_i,
  input  logic                        byp_en_i,
  input  logic [ADDR_W-1:0]           byp_sel_i,
  input  logic [WIDTH-1:0]            byp_data_i,
  output logic [WIDTH-1:0]            data_o,
  output logic                        valid_o
);

  // Out-of-range selects read as empty; a same-cycle write wins over stored data.
  always_comb begin
    data_o  = {WIDTH{1'b0}};
    valid_o = 1'b0;
    if (!idx_in_range(32'(sel_i), DEPTH)) begin
      data_o  = {WIDTH{1'b0}};
      valid_o = 1'b0;
    end else if (byp_en_i && (byp_sel_i == sel_i)) begin
      data_o  = byp_data_i;
      valid_o = 1'b1;
    end else begin
      data_o  = mem_i[sel_i];
      valid_o = vld_i[sel_i];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised two-read-port register file with per-entry valid bits and a sequenced bulk clear.
// Define REGFILE_BYPASS_EN to forward an accepted write to matching read ports in the same cycle.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int              WIDTH     = DEF_WIDTH,
  parameter int              DEPTH     = DEF_DEPTH,
  parameter int              ADDR_W    = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              replace_en,
  input  logic [WIDTH-1:0]  replaceData,
  input  logic [ADDR_W-1:0] replaceSel,
  input  logic [ADDR_W-1:0] A_sel,
  input  logic [ADDR_W-1:0] B_sel,
  output logic [WIDTH-1:0]  A,
  output logic [WIDTH-1:0]  B,
  output logic              A_valid,
  output logic              B_valid,
  input  logic              clear_req,
  output logic              busy,
  output logic              wr_drop
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};

  state_e                      state_q, state_d;
  logic [ADDR_W-1:0]           idx_q, idx_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic                        busy_q, busy_d;
  logic                        wr_drop_q, wr_drop_d;
  logic                        wr_ok_s;
  logic                        byp_en_s;

  // A write is accepted only when the engine is idle and the index exists.
  always_comb begin
    wr_ok_s = replace_en && (state_q == IDLE) && idx_in_range(32'(replaceSel), DEPTH);
`ifdef REGFILE_BYPASS_EN
    byp_en_s = wr_ok_s;
`else
    byp_en_s = 1'b0;
`endif
  end

  // Next-state for storage and the clear engine; a write in IDLE commits before a clear starts.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mem_d   = mem_q;
    vld_d   = vld_q;
    if (wr_ok_s) begin
      mem_d[replaceSel] = replaceData;
      vld_d[replaceSel] = 1'b1;
    end else begin
      mem_d = mem_q;
      vld_d = vld_q;
    end
    case (state_q)
      IDLE: begin
        idx_d = IDX_ZERO;
        if (clear_req) begin
          state_d = CLEAR;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        mem_d[idx_q] = RESET_VAL;
        vld_d[idx_q] = 1'b0;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = IDX_ZERO;
        end else begin
          state_d = CLEAR;
          idx_d   = idx_q + IDX_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = IDX_ZERO;
      end
    endcase
    busy_d    = (state_d == CLEAR);
    wr_drop_d = replace_en && !wr_ok_s;
  end

  // State, storage and registered status flags; reset aborts any clear in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= IDX_ZERO;
      mem_q     <= {DEPTH{RESET_VAL}};
      vld_q     <= {DEPTH{1'b0}};
      busy_q    <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mem_q     <= mem_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  assign busy    = busy_q;
  assign wr_drop = wr_drop_q;

  regfile_rdport #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_rd_a (
    .mem_i     (mem_q),
    .vld_i     (vld_q),
    .sel_i     (A_sel),
    .byp_en_i  (byp_en_s),
    .byp_sel_i (replaceSel),
    .byp_data_i(replaceData),
    .data_o    (A),
    .valid_o   (A_valid)
  );

  regfile_rdport #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_rd_b (
    .mem_i     (mem_q),
    .vld_i     (vld_q),
    .sel_i     (B_sel),
    .byp_en_i  (byp_en_s),
    .byp_sel_i (replaceSel),
    .byp_data_i(replaceData),
    .data_o    (B),
    .valid_o   (B_valid)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a DEPTH=16 and a DEPTH=10 instance share one stimulus stream
// and are checked against an array-based reference model of the register file.
module tb_regfile_mp;

  logic       clk = 1'b0;
  logic       rst_n, replace_en, clear_req;
  logic [7:0] wdata;
  logic [3:0] wsel, a_sel, b_sel;

  logic [7:0] a0, b0, a1, b1;
  logic       av0, bv0, busy0, drop0, av1, bv1, busy1, drop1;

  always #5 clk = ~clk;

  regfile_mp u_dut16 (
    .clk(clk), .rst_n(rst_n), .replace_en(replace_en), .replaceData(wdata),
    .replaceSel(wsel), .A_sel(a_sel), .B_sel(b_sel), .A(a0), .B(b0),
    .A_valid(av0), .B_valid(bv0), .clear_req(clear_req), .busy(busy0), .wr_drop(drop0)
  );

  regfile_mp #(.DEPTH(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .replace_en(replace_en), .replaceData(wdata),
    .replaceSel(wsel), .A_sel(a_sel), .B_sel(b_sel), .A(a1), .B(b1),
    .A_valid(av1), .B_valid(bv1), .clear_req(clear_req), .busy(busy1), .wr_drop(drop1)
  );

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Reference model: plain arrays plus a "clear in progress" flag and position.
  int mem_m   [2][16];
  bit vld_m   [2][16];
  bit busy_m  [2];
  int pos_m   [2];
  bit drop_m  [2];

  typedef struct packed {
    logic [1:0][7:0] a;
    logic [1:0][7:0] b;
    logic [1:0]      av;
    logic [1:0]      bv;
    logic [1:0]      busy;
    logic [1:0]      drop;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic int dep(input int k);
    return (k == 0) ? 16 : 10;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        mem_m[k][i] = 0;
        vld_m[k][i] = 1'b0;
      end
      busy_m[k] = 1'b0;
      pos_m[k]  = 0;
      drop_m[k] = 1'b0;
    end
  endfunction

  function automatic void model_read(input int k, input int sel, output int d, output bit v);
    if (sel >= dep(k)) begin
      d = 0; v = 1'b0;
    end else if (BYP && replace_en && !busy_m[k] && (sel == int'(wsel))) begin
      d = int'(wdata); v = 1'b1;
    end else begin
      d = mem_m[k][sel]; v = vld_m[k][sel];
    end
  endfunction

  function automatic void model_step();
    for (int k = 0; k < 2; k++) begin
      bit drop;
      drop = replace_en && ((int'(wsel) >= dep(k)) || busy_m[k]);
      if (busy_m[k]) begin
        mem_m[k][pos_m[k]] = 0;
        vld_m[k][pos_m[k]] = 1'b0;
        pos_m[k]++;
        if (pos_m[k] == dep(k)) busy_m[k] = 1'b0;
      end else begin
        if (replace_en && (int'(wsel) < dep(k))) begin
          mem_m[k][wsel] = int'(wdata);
          vld_m[k][wsel] = 1'b1;
        end
        if (clear_req) begin
          busy_m[k] = 1'b1;
          pos_m[k]  = 0;
        end
      end
      drop_m[k] = drop;
    end
  endfunction

  function automatic void push_expect();
    exp_t e;
    int   d;
    bit   v;
    for (int k = 0; k < 2; k++) begin
      model_read(k, int'(a_sel), d, v);
      e.a[k] = 8'(d); e.av[k] = v;
      model_read(k, int'(b_sel), d, v);
      e.b[k] = 8'(d); e.bv[k] = v;
      e.busy[k] = busy_m[k];
      e.drop[k] = drop_m[k];
    end
    exp_q.push_back(e);
  endfunction

  task automatic tick();
    push_expect();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic wr(input logic [3:0] s, input logic [7:0] d);
    replace_en = 1'b1;
    wsel       = s;
    wdata      = d;
    tick();
    replace_en = 1'b0;
  endtask

  task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", nm, dep(k), act, expv, $time);
    end
  endtask

  // Monitor: mid-cycle, pop one expectation and compare every output of both instances.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("A",       0, a0,           e.a[0]);
      chk("A_valid", 0, {7'd0, av0},   {7'd0, e.av[0]});
      chk("B",       0, b0,           e.b[0]);
      chk("B_valid", 0, {7'd0, bv0},   {7'd0, e.bv[0]});
      chk("busy",    0, {7'd0, busy0}, {7'd0, e.busy[0]});
      chk("wr_drop", 0, {7'd0, drop0}, {7'd0, e.drop[0]});
      chk("A",       1, a1,           e.a[1]);
      chk("A_valid", 1, {7'd0, av1},   {7'd0, e.av[1]});
      chk("B",       1, b1,           e.b[1]);
      chk("B_valid", 1, {7'd0, bv1},   {7'd0, e.bv[1]});
      chk("busy",    1, {7'd0, busy1}, {7'd0, e.busy[1]});
      chk("wr_drop", 1, {7'd0, drop1}, {7'd0, e.drop[1]});
    end
  end

  initial begin
    rst_n = 1'b0; replace_en = 1'b0; clear_req = 1'b0;
    wdata = 8'h00; wsel = 4'd0; a_sel = 4'd0; b_sel = 4'd0;
    model_reset();
    @(posedge clk);
    #1;
    repeat (3) tick();
    rst_n = 1'b1;

    // Post-reset sweep of every index on both ports.
    for (int i = 0; i < 16; i++) begin
      a_sel = 4'(i); b_sel = 4'(15 - i);
      tick();
    end

    wr(4'd0, 8'hAA);
    wr(4'd1, 8'hBB);
    a_sel = 4'd1; b_sel = 4'd0;
    tick();

    // Same-cycle read of the entry being written.
    a_sel = 4'd2; b_sel = 4'd2;
    wr(4'd2, 8'hCC);
    tick();

    for (int i = 0; i < 16; i++) begin
      a_sel = 4'(i);
      wr(4'(i), 8'(8'h10 + i));
    end

    // Bulk clear with a dropped write and an ignored re-request mid-clear.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int c = 0; c < 18; c++) begin
      replace_en = (c == 3);
      wsel       = 4'd5;
      wdata      = 8'h5A;
      clear_req  = (c == 6);
      a_sel      = 4'(c);
      b_sel      = 4'd5;
      tick();
    end
    replace_en = 1'b0; clear_req = 1'b0;
    a_sel = 4'd5;
    tick();

    // Index 12 exists only in the DEPTH=16 instance.
    a_sel = 4'd12; b_sel = 4'd12;
    wr(4'd12, 8'h77);
    tick();
    a_sel = 4'd9;
    wr(4'd9, 8'h99);
    tick();

    // Reset asserted partway through a clear.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_sel = 4'(i); b_sel = 4'(i);
      tick();
    end

    // Random traffic; read selects often collide with the write select.
    for (int n = 0; n < 600; n++) begin
      replace_en = 1'($urandom_range(0, 1));
      wsel       = 4'($urandom_range(0, 15));
      wdata      = 8'($urandom_range(0, 255));
      clear_req  = ($urandom_range(0, 29) == 0);
      a_sel      = ($urandom_range(0, 3) == 0) ? wsel : 4'($urandom_range(0, 15));
      b_sel      = ($urandom_range(0, 3) == 0) ? wsel : 4'($urandom_range(0, 15));
      tick();
    end
    replace_en = 1'b0; clear_req = 1'b0;

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
